quote_serializer: RTL and testbench
===================================

QUOTE_SERIALIZER -- requirements
Module: quote_serializer

Interface
REQ-001 The block SHALL have one parameter: WORD_BYTES, default 4, the number of bytes in one data word (legal range 2..16).
REQ-002 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset; asserts immediately on falling edge, releases synchronously with clock.
REQ-004 The block SHALL have the port load, input, 1 bit: one-cycle pulse (the upstream data manager's register-enable) requesting capture of word_in.
REQ-005 The block SHALL have the port word_in, input, 8*WORD_BYTES bits: data word sampled on the load cycle.
REQ-006 The block SHALL have the port tx_ready, input, 1 bit: downstream byte transmitter can accept a byte this cycle.
REQ-007 The block SHALL have the port tx_data, output, 8 bits: current byte offered downstream.
REQ-008 The block SHALL have the port tx_valid, output, 1 bit: tx_data is valid this cycle.
REQ-009 The block SHALL have the port busy, output, 1 bit: a word is held or is being sent; high in SEND and DONE.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse after the last byte of a word is accepted.
REQ-011 The block SHALL have the port overrun, output, 1 bit: sticky flag, set when a load arrives while busy.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SEND, DONE; all outputs registered or decoded from registered state only (no combinational path from load/word_in to outputs).
REQ-013 In IDLE, a load=1 cycle SHALL capture word_in into an internal shift register, clear the byte counter, and transition to SEND; otherwise the FSM SHALL remain in IDLE.
REQ-014 In IDLE, outputs SHALL be: tx_valid=0, busy=0, done=0, tx_data=8'h00; tx_ready SHALL be ignored.
REQ-015 In SEND, the block SHALL drive tx_valid=1 and busy=1, with tx_data equal to the most-significant byte of the shift register (MSB-first order).
REQ-016 tx_data SHALL stay constant while tx_valid=1 and tx_ready=0 (no byte dropped, no byte advanced).
REQ-017 A handshake SHALL occur on a cycle with tx_valid=1 and tx_ready=1: the shift register shifts left by 8 (zero fill), and the byte counter increments.
REQ-018 On the handshake where the counter equals WORD_BYTES-1, the FSM SHALL transition to DONE instead of incrementing.
REQ-019 The counter width SHALL be max(1, clog2(WORD_BYTES)) bits, and the counter SHALL never wrap within a word.
REQ-020 In DONE (exactly one cycle), the block SHALL drive done=1, busy=1, and tx_valid=0, then transition unconditionally to IDLE.
REQ-021 Latency SHALL be as follows: load at cycle N gives first tx_valid at N+1. With tx_ready held at 1, the last handshake is at N+WORD_BYTES, done is at N+WORD_BYTES+1, and the next load is accepted from N+WORD_BYTES+2.
REQ-022 A load in SEND or DONE SHALL be ignored (word_in not captured, transfer unaffected) and SHALL set overrun=1 on the following cycle.
REQ-023 overrun SHALL remain 1 until reset; it SHALL NOT be cleared by later loads or completed words.
REQ-024 A load in the same cycle the FSM leaves DONE for IDLE SHALL count as a load in DONE (ignored, overrun set).

Reset
REQ-025 While reset=0, the block SHALL force: state=IDLE, shift register=0, counter=0, tx_valid=0, tx_data=8'h00, busy=0, done=0, overrun=0.
REQ-026 Reset asserted mid-SEND SHALL abandon the word with no done pulse, and the block SHALL accept a new load on the first clock after release.

Verification
REQ-027 The bench SHALL check that, with WORD_BYTES=4 and tx_ready=1, load with word_in=32'hDEADBEEF gives tx_data DE, AD, BE, EF on cycles N+1..N+4, done=1 only at N+5, and busy=0 at N+6.
REQ-028 The bench SHALL check that, with tx_ready held at 0 for 3 cycles after first tx_valid, tx_data=8'h12 (word 32'h12345678) is stable for all 4 cycles and the byte order is unchanged.
REQ-029 The bench SHALL check that a load of 32'hCAFEF00D at N+2 during transfer of 32'h01020304 leaves output bytes 01, 02, 03, 04, sets overrun=1 at N+3, and keeps overrun=1 after the next clean word.
REQ-030 The bench SHALL check that reset=0 asserted during the second byte makes tx_valid, busy, done, overrun, and tx_data all 0 immediately, with no done pulse; a load 1 cycle after release starts a fresh word.
REQ-031 The bench SHALL check that a back-to-back load exactly at the done cycle is ignored with overrun=1, and that a load one cycle later is accepted.
REQ-032 The bench SHALL check that, with WORD_BYTES=2, word 16'hA55A sends A5 then 5A, with done at N+3.

Source files
------------

// File: rtl/quote_serializer_if.sv
// Byte-serializer bus: word load from the upstream data manager, byte
// handshake toward the downstream transmitter, and status flags.
interface quote_serializer_if #(
  parameter int WORD_BYTES = 4
);
  logic                    load;
  logic [8*WORD_BYTES-1:0] word_in;
  logic                    tx_ready;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    busy;
  logic                    done;
  logic                    overrun;

  // Upstream/downstream environment side
  modport master (
    output load, word_in, tx_ready,
    input  tx_data, tx_valid, busy, done, overrun
  );

  // Serializer side
  modport slave (
    input  load, word_in, tx_ready,
    output tx_data, tx_valid, busy, done, overrun
  );
endinterface

// File: rtl/quote_serializer.sv
// Word-to-byte serializer: captures a WORD_BYTES-wide word on a load pulse
// and offers it MSB-first, one byte per tx_valid/tx_ready handshake.
//
//   state | meaning
//   IDLE  | waiting for load; all outputs low, tx_ready ignored
//   SEND  | offering shift-register MSB byte, advancing on handshake
//   DONE  | one-cycle done pulse after the final byte was accepted
module quote_serializer #(
  parameter int WORD_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  quote_serializer_if.slave bus
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 2) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;

  // Byte that becomes visible after the current one is accepted
  logic [7:0]    w_next_byte;
  assign w_next_byte = r_shift[W-9 -: 8];

  // Sequencer, shift register, byte counter and all registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_shift    <= bus.word_in;
            r_cnt      <= '0;
            r_tx_data  <= bus.word_in[W-1 -: 8];
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          // Loads while a word is in flight are dropped and flagged
          if (bus.load) r_overrun <= 1'b1;
          if (bus.tx_ready) begin
            r_shift <= r_shift << 8;
            if (r_cnt == LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cnt     <= r_cnt + CW'(1);
              r_tx_data <= w_next_byte;
            end
          end
        end
        DONE: begin
          // The cycle leaving DONE still counts as busy for overrun purposes
          if (bus.load) r_overrun <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_tx_data  <= 8'h00;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_quote_serializer.sv
// Bench for quote_serializer: a byte-queue reference model checked every
// cycle against the 4-byte instance, plus literal expectations on both the
// 4-byte and 2-byte instances.
module tb_quote_serializer;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  quote_serializer_if #(.WORD_BYTES(4)) bus4 ();
  quote_serializer_if #(.WORD_BYTES(2)) bus2 ();

  quote_serializer #(.WORD_BYTES(4)) dut4 (.clock(clock), .reset(rst_n), .bus(bus4));
  quote_serializer #(.WORD_BYTES(2)) dut2 (.clock(clock), .reset(rst_n), .bus(bus2));

  // Reference model: pending bytes of the current word, done pulse, sticky overrun
  logic [7:0] m_q[$];
  bit         m_done;
  bit         m_over;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Model update on each clock edge or reset assertion
  initial begin
    bit busy_now, next_done;
    m_done = 0;
    m_over = 0;
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_done = 0;
        m_over = 0;
      end else begin
        busy_now  = (m_q.size() != 0) || m_done;
        next_done = 0;
        if (m_q.size() != 0 && bus4.tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) next_done = 1;
        end
        if (bus4.load) begin
          if (busy_now) m_over = 1;
          else for (int k = 3; k >= 0; k--) m_q.push_back(bus4.word_in[8*k +: 8]);
        end
        m_done = next_done;
      end
    end
  end

  // Per-cycle comparison of the 4-byte instance against the model
  initial begin
    logic       e_valid;
    logic [7:0] e_data;
    forever begin
      @(negedge clock);
      e_valid = (m_q.size() != 0);
      e_data  = e_valid ? m_q[0] : 8'h00;
      chk("model_tx_valid", bus4.tx_valid, e_valid);
      chk("model_tx_data",  bus4.tx_data,  e_data);
      chk("model_busy",     bus4.busy,     e_valid || m_done);
      chk("model_done",     bus4.done,     m_done);
      chk("model_overrun",  bus4.overrun,  m_over);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic load4(input logic [31:0] w);
    bus4.word_in = w;
    bus4.load    = 1'b1;
    tick;
    bus4.load    = 1'b0;
    bus4.word_in = '0;
  endtask

  initial begin
    bus4.load = 0; bus4.word_in = '0; bus4.tx_ready = 0;
    bus2.load = 0; bus2.word_in = '0; bus2.tx_ready = 0;
    tick;
    chk("rst_tx_valid", bus4.tx_valid, 0);
    chk("rst_busy",     bus4.busy,     0);
    chk("rst_overrun",  bus4.overrun,  0);
    chk("rst_tx_data",  bus4.tx_data,  8'h00);
    tick;
    rst_n = 1'b1;
    tick;

    // Plain word, tx_ready held high
    bus4.tx_ready = 1;
    load4(32'hDEADBEEF);
    chk("s1_model_size", m_q.size(), 4);
    chk("s1_model_head", m_q[0], 8'hDE);
    chk("s1_b0", bus4.tx_data, 8'hDE);
    chk("s1_v0", bus4.tx_valid, 1);
    chk("s1_d0", bus4.done, 0);
    tick; chk("s1_b1", bus4.tx_data, 8'hAD);
    tick; chk("s1_b2", bus4.tx_data, 8'hBE);
    tick; chk("s1_b3", bus4.tx_data, 8'hEF); chk("s1_d3", bus4.done, 0);
    tick; chk("s1_done", bus4.done, 1); chk("s1_done_valid", bus4.tx_valid, 0);
          chk("s1_done_busy", bus4.busy, 1);
    tick; chk("s1_idle_busy", bus4.busy, 0); chk("s1_idle_done", bus4.done, 0);

    // Back-pressure: tx_ready low for the first three valid cycles
    bus4.tx_ready = 0;
    load4(32'h12345678);
    chk("s2_hold1", bus4.tx_data, 8'h12);
    tick; chk("s2_hold2", bus4.tx_data, 8'h12);
    tick; chk("s2_hold3", bus4.tx_data, 8'h12);
    tick; bus4.tx_ready = 1; chk("s2_hold4", bus4.tx_data, 8'h12); chk("s2_hold4_v", bus4.tx_valid, 1);
    tick; chk("s2_b1", bus4.tx_data, 8'h34);
    tick; chk("s2_b2", bus4.tx_data, 8'h56);
    tick; chk("s2_b3", bus4.tx_data, 8'h78);
    tick; chk("s2_done", bus4.done, 1);
    tick;

    // Load during SEND is ignored and sets sticky overrun
    load4(32'h01020304);
    chk("s3_b0", bus4.tx_data, 8'h01);
    tick; chk("s3_b1", bus4.tx_data, 8'h02); chk("s3_ovr_pre", bus4.overrun, 0);
    bus4.word_in = 32'hCAFEF00D; bus4.load = 1;
    tick; bus4.load = 0; bus4.word_in = '0;
    chk("s3_ovr", bus4.overrun, 1); chk("s3_model_ovr", m_over, 1);
    chk("s3_b2", bus4.tx_data, 8'h03);
    tick; chk("s3_b3", bus4.tx_data, 8'h04);
    tick; chk("s3_done", bus4.done, 1);
    tick;
    load4(32'h11223344);
    chk("s3c_b0", bus4.tx_data, 8'h11);
    tick; tick; tick; chk("s3c_b3", bus4.tx_data, 8'h44);
    tick; chk("s3c_done", bus4.done, 1);
    tick; chk("s3c_ovr_kept", bus4.overrun, 1); chk("s3c_busy", bus4.busy, 0);

    // Reset during the second byte
    load4(32'hAABBCCDD);
    chk("s4_b0", bus4.tx_data, 8'hAA);
    tick; chk("s4_b1", bus4.tx_data, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_valid", bus4.tx_valid, 0);
    chk("s4_rst_busy",  bus4.busy,     0);
    chk("s4_rst_done",  bus4.done,     0);
    chk("s4_rst_ovr",   bus4.overrun,  0);
    chk("s4_rst_data",  bus4.tx_data,  8'h00);
    tick; tick;
    rst_n = 1'b1;
    tick;
    load4(32'h55667788);
    chk("s4_new_b0", bus4.tx_data, 8'h55);
    tick; chk("s4_new_b1", bus4.tx_data, 8'h66);
    tick; chk("s4_new_b2", bus4.tx_data, 8'h77);
    tick; chk("s4_new_b3", bus4.tx_data, 8'h88);
    tick; chk("s4_new_done", bus4.done, 1);
    tick;

    // Load exactly on the done cycle is dropped; the next cycle's load is taken
    load4(32'h0A0B0C0D);
    tick; tick; tick; chk("s5_b3", bus4.tx_data, 8'h0D);
    tick; chk("s5_done", bus4.done, 1);
    bus4.word_in = 32'hF0F0F0F0; bus4.load = 1;
    tick;
    chk("s5_ovr", bus4.overrun, 1); chk("s5_idle_busy", bus4.busy, 0);
    chk("s5_idle_valid", bus4.tx_valid, 0);
    load4(32'h31415926);
    chk("s5_b0", bus4.tx_data, 8'h31);
    tick; chk("s5_b1", bus4.tx_data, 8'h41);
    tick; chk("s5_b2", bus4.tx_data, 8'h59);
    tick; chk("s5_b3x", bus4.tx_data, 8'h26);
    tick; chk("s5_done2", bus4.done, 1);
    tick;

    // Two-byte instance
    bus2.tx_ready = 1;
    bus2.word_in = 16'hA55A; bus2.load = 1;
    tick; bus2.load = 0; bus2.word_in = '0;
    chk("w2_b0", bus2.tx_data, 8'hA5); chk("w2_v0", bus2.tx_valid, 1);
    tick; chk("w2_b1", bus2.tx_data, 8'h5A); chk("w2_d1", bus2.done, 0);
    tick; chk("w2_done", bus2.done, 1); chk("w2_done_valid", bus2.tx_valid, 0);
    tick; chk("w2_idle_busy", bus2.busy, 0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
